// File: rtl/bcd_bin_loader.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble) with
// range check against modulus N; emits a one-cycle load strobe or error pulse.
module bcd_bin_loader #(
    parameter int N = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] bcd,
    output logic [7:0] bin,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [8:0] N_LIMIT = 9'(N);

    state_t      state_q, state_d;
    logic [17:0] s_q, s_d;
    logic        bad_q, bad_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  bin_q, bin_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [17:0] shifted;
    logic [3:0]  tens_adj;
    logic [3:0]  ones_adj;
    logic        out_of_range;

    // One reverse double-dabble step: shift right, then undo the x2 carry
    // that landed in a BCD field by subtracting 3 from any field >= 8.
    assign shifted  = {1'b0, s_q[17:1]};
    assign tens_adj = (shifted[15:12] >= 4'd8) ? shifted[15:12] - 4'd3 : shifted[15:12];
    assign ones_adj = (shifted[11:8]  >= 4'd8) ? shifted[11:8]  - 4'd3 : shifted[11:8];

    assign out_of_range = (s_q[17:8] != 10'd0) || ({1'b0, s_q[7:0]} >= N_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values.
            state_q <= state_d;
            s_q     <= s_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d = state_q;
        s_d     = s_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d     = {bcd, 8'b0};
                    bad_d   = (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                s_d   = {shifted[17:16], tens_adj, ones_adj, shifted[7:0]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bad_q || out_of_range) begin
                    err_d = 1'b1;
                end else begin
                    bin_d   = s_q[7:0];
                    valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bin   = bin_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule
